// File: rtl/cellular_automaton_param_pkg.sv
// Shared constants and operating-mode encoding for the 1-D cellular automaton.
package ca_pkg;
    localparam int RULE_WIDTH = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        STEP = 2'd1,
        FREE = 2'd2
    } caState_t;
endpackage

// File: rtl/cellular_automaton_param_if.sv
// Control/status bundle between the debounced front panel and the automaton core.
interface cellular_automaton_param_if #(
    parameter int WIDTH = 9,
    parameter int GEN_W = 16
);
    logic             sButton;
    logic             rButton;
    logic             loadOrRun;
    logic [WIDTH-1:0] slideSwitches;
    logic [7:0]       rule;
    logic             wrapEn;
    logic [WIDTH-1:0] currentLifeState;
    logic [GEN_W-1:0] generation;
    logic             stable;
    logic             running;

    modport master (
        output sButton, rButton, loadOrRun, slideSwitches, rule, wrapEn,
        input  currentLifeState, generation, stable, running
    );

    modport slave (
        input  sButton, rButton, loadOrRun, slideSwitches, rule, wrapEn,
        output currentLifeState, generation, stable, running
    );
endinterface

// File: rtl/cellular_automaton_param_next_gen.sv
// Combinational next-generation computation: each cell looks up its 3-bit
// neighbourhood {left, self, right} in the rule byte.
module ca_next_gen
    import ca_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0]      cells,
    input  logic [RULE_WIDTH-1:0] rule,
    input  logic                  wrapEn,
    output logic [WIDTH-1:0]      nextCells
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gCell
            logic leftBit;
            logic rightBit;

            // Edge cells either wrap around the ring or see a dead neighbour.
            if (gi == WIDTH - 1) begin : gLeftEdge
                assign leftBit = wrapEn & cells[0];
            end else begin : gLeftInner
                assign leftBit = cells[gi+1];
            end

            if (gi == 0) begin : gRightEdge
                assign rightBit = wrapEn & cells[WIDTH-1];
            end else begin : gRightInner
                assign rightBit = cells[gi-1];
            end

            assign nextCells[gi] = rule[{leftBit, cells[gi], rightBit}];
        end
    endgenerate
endmodule

// File: rtl/cellular_automaton_param.sv
// Elementary cellular automaton core: seed load, single-step and timed free-run
// with generation counting and fixed-point auto-halt.
module cellular_automaton_param
    import ca_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int GEN_W    = 16,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    cellular_automaton_param_if.slave bus
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    caState_t         stateReg, stateNext, curMode;
    logic [WIDTH-1:0] cellsReg, cellsNext;
    logic [WIDTH-1:0] nextGen;
    logic [GEN_W-1:0] genReg, genNext;
    logic [TICK_W-1:0] tickReg, tickNext;
    logic             stableReg, stableNext;
    logic             sPrevReg, rPrevReg;
    logic             sPulse, rPulse, advance;

    ca_next_gen #(.WIDTH(WIDTH)) uNextGen (
        .cells     (cellsReg),
        .rule      (bus.rule),
        .wrapEn    (bus.wrapEn),
        .nextCells (nextGen)
    );

    assign sPulse = bus.sButton & ~sPrevReg;
    assign rPulse = bus.rButton & ~rPrevReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= LOAD;
            cellsReg  <= '0;
            genReg    <= '0;
            tickReg   <= '0;
            stableReg <= 1'b0;
            sPrevReg  <= 1'b0;
            rPrevReg  <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            cellsReg  <= cellsNext;
            genReg    <= genNext;
            tickReg   <= tickNext;
            stableReg <= stableNext;
            sPrevReg  <= bus.sButton;
            rPrevReg  <= bus.rButton;
        end
    end

    // The load/run switch overrides the registered mode immediately.
    always_comb begin
        curMode = LOAD;
        if (bus.loadOrRun) begin
            curMode = (stateReg == FREE) ? FREE : STEP;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        cellsNext  = cellsReg;
        genNext    = genReg;
        tickNext   = tickReg;
        stableNext = stableReg;
        advance    = 1'b0;

        case (curMode)
            LOAD: begin
                stateNext  = LOAD;
                cellsNext  = bus.slideSwitches;
                genNext    = '0;
                stableNext = 1'b0;
                tickNext   = '0;
            end
            STEP: begin
                stateNext = STEP;
                advance   = sPulse;
                if (rPulse) begin
                    stateNext = FREE;
                    tickNext  = '0;
                end
            end
            FREE: begin
                if (tickReg == TICK_LAST) begin
                    tickNext = '0;
                    advance  = 1'b1;
                    if (nextGen == cellsReg) begin
                        stateNext = STEP;
                    end
                end else begin
                    tickNext = tickReg + 1'b1;
                end
                if (rPulse) begin
                    stateNext = STEP;
                end
            end
            default: stateNext = LOAD;
        endcase

        if (advance) begin
            cellsNext  = nextGen;
            stableNext = (nextGen == cellsReg);
            genNext    = (genReg == '1) ? genReg : genReg + 1'b1;
        end
    end

    assign bus.currentLifeState = cellsReg;
    assign bus.generation       = genReg;
    assign bus.stable           = stableReg;
    assign bus.running          = (stateReg == FREE);
endmodule

// File: tb/tb_cellular_automaton_param.sv
// Directed plus randomized checking of the automaton against a behavioural
// model built from the neighbourhood-lookup rule and the mode rules.
module tb_cellular_automaton_param;
    localparam int W  = 9;
    localparam int GW = 16;
    localparam int TD = 4;

    logic clk;
    logic reset;

    cellular_automaton_param_if #(.WIDTH(W), .GEN_W(GW)) bus ();

    cellular_automaton_param #(.WIDTH(W), .GEN_W(GW), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] mCells;
    int           mGen;
    bit           mStable;
    bit           mRun;
    int           mCnt;
    bit           tbSPrev;
    bit           tbRPrev;

    function automatic int cellAt(logic [W-1:0] c, int j, logic w);
        if (j >= 0 && j < W) return int'(c[j]);
        if (!w) return 0;
        return int'(c[(j + W) % W]);
    endfunction

    function automatic logic [W-1:0] refNext(logic [W-1:0] c, logic [7:0] r, logic w);
        logic [W-1:0] n;
        for (int i = 0; i < W; i++) begin
            int idx;
            idx = cellAt(c, i + 1, w) * 4 + cellAt(c, i, w) * 2 + cellAt(c, i - 1, w);
            n[i] = r[idx];
        end
        return n;
    endfunction

    function automatic void modelReset();
        mCells = '0; mGen = 0; mStable = 0; mRun = 0; mCnt = 0;
        tbSPrev = 0; tbRPrev = 0;
    endfunction

    // Returns 1 when the generation actually changed.
    function automatic bit modelAdvance();
        logic [W-1:0] n;
        n = refNext(mCells, bus.rule, bus.wrapEn);
        mStable = (n == mCells);
        mCells = n;
        if (mGen < (1 << GW) - 1) mGen++;
        return !mStable;
    endfunction

    function automatic void modelCycle(bit sP, bit rP);
        if (!bus.loadOrRun) begin
            mCells = bus.slideSwitches; mGen = 0; mStable = 0; mRun = 0; mCnt = 0;
        end else if (!mRun) begin
            if (sP) void'(modelAdvance());
            if (rP) begin mRun = 1; mCnt = 0; end
        end else begin
            mCnt++;
            if (mCnt == TD) begin
                mCnt = 0;
                if (!modelAdvance()) mRun = 0;
            end
            if (rP) mRun = 0;
        end
    endfunction

    task automatic cycle();
        bit sP, rP;
        @(posedge clk);
        sP = bus.sButton && !tbSPrev;
        rP = bus.rButton && !tbRPrev;
        if (reset) begin
            tbSPrev = 0; tbRPrev = 0;
        end else begin
            tbSPrev = bus.sButton; tbRPrev = bus.rButton;
            modelCycle(sP, rP);
        end
        @(negedge clk);
    endtask

    task automatic runCycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(string tag);
        checkVal({tag, ".cells"},   32'(bus.currentLifeState), 32'(mCells));
        checkVal({tag, ".gen"},     32'(bus.generation),       32'(mGen));
        checkVal({tag, ".stable"},  32'(bus.stable),           32'(mStable));
        checkVal({tag, ".running"}, 32'(bus.running),          32'(mRun));
    endtask

    task automatic loadSeed(logic [W-1:0] seed, logic [7:0] r, logic w);
        bus.rule = r; bus.wrapEn = w;
        bus.loadOrRun = 1'b0; bus.slideSwitches = seed;
        cycle();
        bus.loadOrRun = 1'b1;
        $display("load seed=%b rule=%0d wrap=%0d -> cells=%b", seed, r, w, bus.currentLifeState);
    endtask

    task automatic stepOnce();
        bus.sButton = 1'b1; cycle();
        bus.sButton = 1'b0; cycle();
        $display("step -> cells=%b gen=%0d stable=%0d", bus.currentLifeState, bus.generation, bus.stable);
    endtask

    task automatic pulseRun();
        bus.rButton = 1'b1; cycle();
        bus.rButton = 1'b0;
        $display("run toggle -> running=%0d", bus.running);
    endtask

    initial begin
        reset = 1'b1;
        bus.sButton = 0; bus.rButton = 0; bus.loadOrRun = 0;
        bus.slideSwitches = '0; bus.rule = 8'd0; bus.wrapEn = 0;
        modelReset();
        @(negedge clk); @(negedge clk);
        checkAll("reset");
        reset = 1'b0;

        // Rule 90, no wrap, two single steps.
        loadSeed(9'b000010000, 8'd90, 1'b0);
        stepOnce();
        checkVal("r90.g1", 32'(bus.currentLifeState), 32'(9'b000101000));
        stepOnce();
        checkVal("r90.g2", 32'(bus.currentLifeState), 32'(9'b001000100));
        checkVal("r90.gen", 32'(bus.generation), 32'd2);
        checkAll("r90");

        // Boundary behaviour at the top cell.
        loadSeed(9'b100000000, 8'd90, 1'b1);
        stepOnce();
        checkVal("wrap1", 32'(bus.currentLifeState), 32'(9'b010000001));
        loadSeed(9'b100000000, 8'd90, 1'b0);
        stepOnce();
        checkVal("wrap0", 32'(bus.currentLifeState), 32'(9'b010000000));
        checkAll("wrap0");

        // Identity rule gives an immediate fixed point.
        loadSeed(9'b001011010, 8'd204, 1'b0);
        stepOnce();
        checkVal("r204.cells", 32'(bus.currentLifeState), 32'(9'b001011010));
        checkVal("r204.stable", 32'(bus.stable), 32'd1);
        checkVal("r204.gen", 32'(bus.generation), 32'd1);

        // Timed free-run then stop.
        loadSeed(9'b000010000, 8'd90, 1'b0);
        pulseRun();
        runCycles(20);
        checkVal("free.gen", 32'(bus.generation), 32'd5);
        checkVal("free.running", 32'(bus.running), 32'd1);
        checkAll("free");
        pulseRun();
        cycle();
        checkVal("free.stop", 32'(bus.running), 32'd0);
        checkAll("freeStop");

        // Rule 0 dies out and auto-halts.
        loadSeed(9'b000010000, 8'd0, 1'b0);
        pulseRun();
        runCycles(4);
        checkVal("r0.cells", 32'(bus.currentLifeState), 32'd0);
        checkVal("r0.stable1", 32'(bus.stable), 32'd0);
        runCycles(4);
        checkVal("r0.stable2", 32'(bus.stable), 32'd1);
        checkVal("r0.halt", 32'(bus.running), 32'd0);
        checkAll("r0");

        // Simultaneous step and run requests.
        loadSeed(9'b000110000, 8'd30, 1'b1);
        bus.sButton = 1; bus.rButton = 1; cycle();
        bus.sButton = 0; bus.rButton = 0;
        checkVal("both.gen", 32'(bus.generation), 32'd1);
        checkVal("both.running", 32'(bus.running), 32'd1);
        runCycles(4);
        checkAll("both");

        // Randomized operation compared cycle by cycle.
        for (int i = 0; i < 120; i++) begin
            bus.loadOrRun     = ($urandom_range(0, 9) != 0);
            bus.sButton       = ($urandom_range(0, 2) == 0);
            bus.rButton       = ($urandom_range(0, 5) == 0);
            bus.slideSwitches = W'($urandom);
            bus.wrapEn        = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) bus.rule = 8'($urandom);
            cycle();
            checkAll("rand");
        end
        bus.sButton = 0; bus.rButton = 0;

        // Asynchronous reset in the middle of a free-run.
        loadSeed(9'b000010000, 8'd90, 1'b0);
        pulseRun();
        runCycles(6);
        bus.sButton = 1'b1;
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkAll("asyncReset");
        @(negedge clk);
        bus.loadOrRun = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        bus.loadOrRun = 1'b1;
        runCycles(3);
        checkVal("held.gen", 32'(bus.generation), 32'd0);
        checkAll("held");
        bus.sButton = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
